// File: rtl/ifetch_if.sv
// ifetch_if -- bundle of the fetch-unit control, redirect-operand and
// instruction-memory signals.
//
// Valid/ready note: this bus has no handshake. Every signal is meaningful in
// every cycle. Control inputs are sampled at the rising edge of clk, and the
// fetch outputs are valid from shortly after that edge until the next one.
//
// Signals (directions as seen by the fetch unit, modport slave):
//   stall        in   freeze PC and fetch-side pipe registers
//   branch_taken in   conditional branch resolved taken (EX-aligned)
//   jump         in   J-type jump (EX-aligned)
//   jr           in   jump-register (EX-aligned)
//   seOut        in   sign-extended immediate of the EX instruction
//   reg_Da       in   rs value of the EX instruction
//   imem_data    in   instruction word at imem_addr (combinational read)
//   imem_addr    out  instruction memory byte address (= PC)
//   Instructions out  fetched word handed to the IF/ID register
//   squash_id    out  kill request for the instruction currently in ID
//   pc_plus4     out  PC+4 of the current fetch
//
// The master modport is the datapath/memory side of the same bus.
interface ifetch_if;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [31:0] seOut;
    logic [31:0] reg_Da;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] Instructions;
    logic        squash_id;
    logic [31:0] pc_plus4;

    modport slave (
        input  stall, branch_taken, jump, jr, seOut, reg_Da, imem_data,
        output imem_addr, Instructions, squash_id, pc_plus4
    );

    modport master (
        output stall, branch_taken, jump, jr, seOut, reg_Da, imem_data,
        input  imem_addr, Instructions, squash_id, pc_plus4
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch stage with an EX-resolved redirect.
//
// The unit holds the PC and presents it as imem_addr. Two small pipes carry
// PC+4 and the fetched word down to EX, so that a jump or branch resolved in
// EX can compute its target from its own PC+4 and instruction bits.
//
// Redirect rules:
//   - A redirect (jr | jump | branch_taken) NOPs the fetch of the current
//     cycle and loads the target at the clock edge.
//   - The target is chosen with priority jr > jump > branch.
//   - A redirect wins over stall.
//   - A reset cycle ignores the redirect inputs.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   NOP_WORD  instruction word substituted for squashed fetches
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous, active-high reset
//   bus  ifetch_if.slave (see rtl/ifetch_if.sv)
//
// Build option: define IFETCH_DELAY_SLOT_EN to treat the instruction in ID
// as a branch delay slot. In that build squash_id stays 0. The fetch made in
// the redirect cycle is still replaced by NOP_WORD.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input logic     clk,
    input logic     rst,
    ifetch_if.slave bus
);

    logic [31:0] pc;
    logic [31:0] pc4_id;
    logic [31:0] pc4_ex;
    // Only the 26-bit jump index field of an instruction is ever consumed
    // downstream of IF, so the instruction pipe keeps just that field.
    logic [25:0] ins_id;
    logic [25:0] ins_ex;

    logic        redirect;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic [31:0] fetch_word;
    logic        shift;

    always_comb begin
        pc_inc   = pc + 32'd4;
        // A reset cycle must not act on stale redirect inputs.
        redirect = !rst && (bus.jr || bus.jump || bus.branch_taken);

        if (bus.jr) begin
            target = bus.reg_Da;
        end else if (bus.jump) begin
            target = {pc4_ex[31:28], ins_ex, 2'b00};
        end else begin
            target = pc4_ex + (bus.seOut << 2);
        end

        if (rst || redirect) begin
            fetch_word = NOP_WORD;
        end else begin
            fetch_word = bus.imem_data;
        end

        // A redirect pushes a NOP bubble into ID even while stalled.
        shift = redirect || !bus.stall;
    end

    assign bus.imem_addr    = pc;
    assign bus.pc_plus4     = pc_inc;
    assign bus.Instructions = fetch_word;
`ifdef IFETCH_DELAY_SLOT_EN
    assign bus.squash_id    = 1'b0;
`else
    assign bus.squash_id    = redirect;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            pc4_id <= 32'h00000000;
            pc4_ex <= 32'h00000000;
            ins_id <= NOP_WORD[25:0];
            ins_ex <= NOP_WORD[25:0];
        end else begin
            if (redirect) begin
                pc <= target;
            end else if (!bus.stall) begin
                pc <= pc_inc;
            end

            if (shift) begin
                pc4_id <= pc_inc;
                pc4_ex <= pc4_id;
                ins_id <= fetch_word[25:0];
                ins_ex <= ins_id;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit -- bench for ifetch_unit.
//
// A driver task applies one cycle of inputs just after the rising edge. It
// then asks a reference model what the outputs must be in that cycle and
// pushes that expectation into exp_q. A separate monitor pops the queue on
// every falling edge and compares the popped entry against the DUT outputs.
//
// The model keeps the PC as a number. It keeps the (PC+4, word) history of
// the last two accepted fetches in a queue.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP      = 32'h00000020;
    localparam int          W        = 98;   // {chk, addr, ins, sq, p4}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_if bus ();

    ifetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: 1024 words, aliased over the address space.
    logic [31:0] mem [0:1023];
    assign bus.imem_data = mem[bus.imem_addr[11:2]];

    // Scoreboard state.
    logic [W-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_known = 1'b0;
    logic [63:0] hist [$];   // hist[0] = ID entry, hist[1] = EX entry; {pc4, ins}

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check32("instructions", bus.Instructions, e[64:33]);
            check32("squash_id", {31'd0, bus.squash_id}, {31'd0, e[32]});
            if (e[97]) begin
                check32("imem_addr", bus.imem_addr, e[96:65]);
                check32("pc_plus4", bus.pc_plus4, e[31:0]);
            end
        end
    end

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_known = 1'b1;
        hist    = {};
        hist.push_back({32'd0, NOP});
        hist.push_back({32'd0, NOP});
    endtask

    task automatic cycle(input logic r, input logic s, input logic b, input logic j,
                         input logic jrr, input logic [31:0] se, input logic [31:0] rd);
        logic        redir;
        logic        sq;
        logic [31:0] ins;
        logic [31:0] nxt;
        logic [31:0] ex_pc4;
        logic [31:0] ex_ins;
        @(posedge clk);
        #1;
        rst              = r;
        bus.stall        = s;
        bus.branch_taken = b;
        bus.jump         = j;
        bus.jr           = jrr;
        bus.seOut        = se;
        bus.reg_Da       = rd;

        redir = !r && (b || j || jrr);
`ifdef IFETCH_DELAY_SLOT_EN
        sq = 1'b0;
`else
        sq = redir;
`endif
        if (r || redir) ins = NOP;
        else            ins = mem[m_pc[11:2]];
        exp_q.push_back({m_known, m_pc, ins, sq, m_pc + 32'd4});

        if (r) begin
            model_reset();
        end else begin
            ex_pc4 = hist[1][63:32];
            ex_ins = hist[1][31:0];
            if (jrr)       nxt = rd;
            else if (j)    nxt = {ex_pc4[31:28], ex_ins[25:0], 2'b00};
            else if (b)    nxt = ex_pc4 + se * 32'd4;
            else if (s)    nxt = m_pc;
            else           nxt = m_pc + 32'd4;
            if (redir || !s) begin
                hist.push_front({m_pc + 32'd4, ins});
                void'(hist.pop_back());
            end
            m_pc = nxt;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        bus.jr           = 1'b0;
        bus.seOut        = 32'd0;
        bus.reg_Da       = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[8]   = 32'h08000040;   // word at 0x20
        mem[256] = 32'h08000040;   // word at 0x400

        // Reset release: fetches 0x0, 0x4, then a three-cycle stall at 0x8.
        cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
        run(2);
        repeat (3) cycle(0, 1, 0, 0, 0, 32'd0, 32'd0);
        run(2);

        // Branch from the instruction at 0x10 with seOut = 3 lands on 0x20.
        cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
        run(6);
        cycle(0, 0, 1, 0, 0, 32'h00000003, 32'd0);
        run(2);
        // jr beats jump; then a lone jump with the word 0x08000040 in EX.
        cycle(0, 0, 0, 1, 1, 32'd0, 32'h00000400);
        run(2);
        cycle(0, 0, 0, 1, 0, 32'd0, 32'd0);
        run(2);

        // Stall together with a backward branch (seOut = -1).
        cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
        run(6);
        cycle(0, 1, 1, 0, 0, 32'hFFFFFFFF, 32'd0);
        run(2);

        // PC wrap at the top of the address space, then reset beats jr.
        cycle(0, 0, 0, 0, 1, 32'd0, 32'hFFFFFFFC);
        run(2);
        cycle(1, 0, 0, 0, 1, 32'd0, 32'h00000500);
        run(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] se;
            logic [31:0] rd;
            se = ($urandom_range(0, 3) == 0) ? $urandom
                                              : 32'($signed($urandom_range(0, 64)) - 32);
            rd = {$urandom_range(0, 255), 2'b00} | {30'd0, 2'($urandom_range(0, 3) == 0)};
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 13) == 0,
                  se, rd);
        end

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_WORD, default 32'h00000000, instruction word substituted for squashed fetches.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  freeze PC and fetch-side pipe registers.
REQ-006 SHALL have port branch_taken  input  1  conditional branch resolved taken, EX-aligned.
REQ-007 SHALL have port jump  input  1  J-type jump, EX-aligned.
REQ-008 SHALL have port jr  input  1  jump-register, EX-aligned.
REQ-009 SHALL have port seOut  input  32  sign-extended immediate of EX instruction, from datapath ID/EX output.
REQ-010 SHALL have port reg_Da  input  32  rs value of EX instruction, from datapath ID/EX output.
REQ-011 SHALL have port imem_addr  output  32  instruction memory byte address; equals PC.
REQ-012 SHALL have port imem_data  input  32  instruction word at imem_addr, combinational read.
REQ-013 SHALL have port Instructions  output  32  fetched word to datapath IF/ID register.
REQ-014 SHALL have port squash_id  output  1  kill request for instruction currently in ID.
REQ-015 SHALL have port pc_plus4  output  32  PC+4 of current fetch.

Function
REQ-016 SHALL hold PC register; imem_addr = PC.
REQ-017 SHALL keep 2-deep PC+4 pipe (pc4_id, pc4_ex) and 2-deep instruction pipe (ins_id, ins_ex), shifting each non-stalled cycle, so pc4_ex/ins_ex align with seOut/reg_Da.
REQ-018 SHALL define redirect = jr | jump | branch_taken.
REQ-019 SHALL select target with priority jr > jump > branch_taken: jr -> reg_Da; jump -> {pc4_ex[31:28], ins_ex[25:0], 2'b00}; branch -> pc4_ex + (seOut << 2), 32-bit modulo, no overflow flag.
REQ-020 SHALL, on redirect in cycle t, drive Instructions = NOP_WORD combinationally in cycle t and load PC <= target at end of t.
REQ-021 SHALL, with no redirect and stall=0, load PC <= PC+4 (wrap 32'hFFFFFFFC -> 0) and drive Instructions = imem_data.
REQ-022 SHALL, with stall=1 and no redirect, hold PC and both pipes; Instructions = imem_data at held PC.
REQ-023 SHALL give redirect priority over stall: PC loads target and pipes shift with NOP_WORD entering ins_id.
REQ-024 SHALL assert squash_id combinationally in any redirect cycle unless delay slots are enabled (REQ-030).
REQ-025 SHALL keep squash_id 0 in non-redirect cycles.
REQ-026 SHALL ignore jr/jump/branch_taken in a cycle with rst=1.

Reset
REQ-027 SHALL on rst set PC = RESET_PC, pc4_id = pc4_ex = 0, ins_id = ins_ex = NOP_WORD.
REQ-028 SHALL drive Instructions = NOP_WORD and squash_id = 0 while rst=1; first real fetch at RESET_PC in the cycle after rst deasserts.
REQ-029 SHALL abandon any in-flight redirect when rst asserts mid-operation.

Configuration
REQ-030 SHALL honour macro IFETCH_DELAY_SLOT_EN: defined -> squash_id held 0 (ID instruction executes as branch delay slot), fetch in redirect cycle still NOP'd; undefined -> squash_id per REQ-024.

Verification
REQ-031 Reset: rst 1 cycle, release -> imem_addr=0, 0x4, 0x8 on successive cycles; Instructions=NOP_WORD during rst.
REQ-032 Branch: insn at 0x10 in EX, branch_taken=1, seOut=32'h00000003 -> Instructions=NOP that cycle, next imem_addr=0x20, squash_id=1 (0 with IFETCH_DELAY_SLOT_EN).
REQ-033 Jump/jr priority: jump=1, jr=1, reg_Da=32'h00000400, ins_ex=32'h08000040 -> next imem_addr=0x400; jump alone -> 0x100.
REQ-034 Stall: stall=1 for 3 cycles at PC=0x8 -> imem_addr stays 0x8, pipes unchanged; release -> 0xC.
REQ-035 Stall+redirect: stall=1, branch_taken=1, pc4_ex=0x14, seOut=32'hFFFFFFFF -> next imem_addr=0x10.
REQ-036 Wrap/reset-mid-op: PC=32'hFFFFFFFC -> next 0; assert rst same cycle as jr -> PC=RESET_PC.
